// File: rtl/data_demux.sv
// data_demux: one-deep slot per active destination, valid-tagged outputs.
// Unicast or broadcast delivery with same-cycle refill of draining slots.
// Out-of-range unicast words are dropped and raise a sticky error flag.
module data_demux #(
  parameter int NUM_OUTPUTS = 4,
  parameter int BIT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic [3:0]           in_sel,
  input  logic                 in_bcast,
  output logic [BIT_WIDTH:0]   out0,
  output logic [BIT_WIDTH:0]   out1,
  output logic [BIT_WIDTH:0]   out2,
  output logic [BIT_WIDTH:0]   out3,
  output logic [BIT_WIDTH:0]   out4,
  output logic [BIT_WIDTH:0]   out5,
  output logic [BIT_WIDTH:0]   out6,
  output logic [BIT_WIDTH:0]   out7,
  output logic [BIT_WIDTH:0]   out8,
  output logic [BIT_WIDTH:0]   out9,
  output logic [BIT_WIDTH:0]   out10,
  output logic [BIT_WIDTH:0]   out11,
  output logic [BIT_WIDTH:0]   out12,
  output logic [BIT_WIDTH:0]   out13,
  output logic [BIT_WIDTH:0]   out14,
  output logic [BIT_WIDTH:0]   out15,
  input  logic [15:0]          out_ready,
  output logic                 err_sel,
  output logic [15:0]          accept_cnt
);

  typedef enum logic {S_EMPTY, S_FULL} slot_t;

  // Bit N set when destination N exists.
  localparam logic [15:0] ACTIVE = 16'((32'h1 << NUM_OUTPUTS) - 32'h1);

  slot_t                state   [16];
  logic [BIT_WIDTH-1:0] payload [16];
  logic [BIT_WIDTH:0]   outv    [16];
  logic [15:0]          full;
  logic [15:0]          free;
  logic [15:0]          fill;
  logic                 sel_ok;
  logic                 accept;

  assign sel_ok = {1'b0, in_sel} < 5'(NUM_OUTPUTS);
  assign accept = in_valid & in_ready;

  // Slot occupancy and "can take a word this edge" per destination.
  always_comb begin
    full = '0;
    free = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      full[i] = ACTIVE[i] & (state[i] == S_FULL);
      free[i] = ~full[i] | out_ready[i];
    end
  end

  // Upstream handshake; independent of in_valid, held low during reset.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (in_bcast)
        in_ready = &(free | ~ACTIVE);
      else if (!sel_ok)
        in_ready = 1'b1;
      else
        in_ready = free[in_sel];
    end
  end

  // Which slots load the incoming word this edge.
  always_comb begin
    fill = '0;
    for (int unsigned i = 0; i < 16; i++)
      fill[i] = accept & ACTIVE[i] & (in_bcast | (sel_ok & (in_sel == 4'(i))));
  end

  // Slot state, payload, error flag and acceptance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        state[i]   <= S_EMPTY;
        payload[i] <= '0;
      end
      err_sel    <= 1'b0;
      accept_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (fill[i]) begin
          state[i]   <= S_FULL;
          payload[i] <= in_data;
        end else if (full[i] && out_ready[i]) begin
          state[i] <= S_EMPTY;
        end
      end
      if (accept && !in_bcast && !sel_ok)
        err_sel <= 1'b1;
      if (accept && (in_bcast || sel_ok))
        accept_cnt <= accept_cnt + 16'd1;
    end
  end

  // Valid-tagged output words; payload forced to zero when the slot is empty.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++)
      outv[i] = full[i] ? {1'b1, payload[i]} : '0;
  end

  assign out0  = outv[0];
  assign out1  = outv[1];
  assign out2  = outv[2];
  assign out3  = outv[3];
  assign out4  = outv[4];
  assign out5  = outv[5];
  assign out6  = outv[6];
  assign out7  = outv[7];
  assign out8  = outv[8];
  assign out9  = outv[9];
  assign out10 = outv[10];
  assign out11 = outv[11];
  assign out12 = outv[12];
  assign out13 = outv[13];
  assign out14 = outv[14];
  assign out15 = outv[15];

endmodule

// File: tb/tb_data_demux.sv
// Directed self-checking bench for data_demux (NUM_OUTPUTS=4, BIT_WIDTH=32).
module tb_data_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_sel;
  logic        in_bcast;
  logic [32:0] o [16];
  logic [15:0] out_ready;
  logic        err_sel;
  logic [15:0] accept_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_demux #(.NUM_OUTPUTS(4), .BIT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
    .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
    .out8(o[8]), .out9(o[9]), .out10(o[10]), .out11(o[11]),
    .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
    .out_ready(out_ready), .err_sel(err_sel), .accept_cnt(accept_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [32:0] e0, input logic [32:0] e1,
                          input logic [32:0] e2, input logic [32:0] e3);
    chk({tag, "_o0"}, o[0], e0);
    chk({tag, "_o1"}, o[1], e1);
    chk({tag, "_o2"}, o[2], e2);
    chk({tag, "_o3"}, o[3], e3);
  endtask

  task automatic chk_upper(input string tag);
    for (int i = 4; i < 16; i++) chk($sformatf("%s_o%0d", tag, i), o[i], 33'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
    out_ready = '0;
    #3;
    chk_outs("rst", 33'h0, 33'h0, 33'h0, 33'h0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_err", err_sel, 1'b0);
    chk("rst_cnt", accept_cnt, 16'h0);
    tick;
    #2 rst_n = 1'b1;
    tick;

    // Unicast to slot 2, nobody consuming.
    in_valid = 1'b1; in_sel = 4'd2; in_data = 32'hDEADBEEF;
    #1 chk("uni_ready", in_ready, 1'b1);
    tick;
    in_data = 32'hCAFEF00D;
    #1;
    chk_outs("uni", 33'h0, 33'h0, 33'h1_DEADBEEF, 33'h0);
    chk_upper("uni");
    chk("uni_cnt", accept_cnt, 16'd1);
    chk("uni_ready2", in_ready, 1'b0);
    tick;
    chk("uni_hold", o[2], 33'h1_DEADBEEF);
    chk("uni_cnt2", accept_cnt, 16'd1);

    // Back-to-back to slot 1 with constant consumption; slot 2 drains too.
    out_ready = 16'h0006; in_sel = 4'd1; in_data = 32'h1;
    #1 chk("b2b_ready1", in_ready, 1'b1);
    tick;
    chk("b2b_o1a", o[1], 33'h1_00000001);
    chk("b2b_o2drain", o[2], 33'h0);
    in_data = 32'h2;
    #1 chk("b2b_ready2", in_ready, 1'b1);
    tick;
    chk("b2b_o1b", o[1], 33'h1_00000002);
    in_data = 32'h3;
    #1 chk("b2b_ready3", in_ready, 1'b1);
    tick;
    chk("b2b_o1c", o[1], 33'h1_00000003);
    chk("b2b_cnt", accept_cnt, 16'd4);
    in_valid = 1'b0;
    tick;
    chk("b2b_o1drain", o[1], 33'h0);

    // Broadcast blocked by full slot 3, released when slot 3 drains.
    out_ready = '0; in_valid = 1'b1; in_sel = 4'd3; in_data = 32'h33;
    tick;
    chk("bc_pre_o3", o[3], 33'h1_00000033);
    in_bcast = 1'b1; in_data = 32'hB0B0B0B0;
    #1 chk("bc_blocked", in_ready, 1'b0);
    tick;
    chk_outs("bc_wait", 33'h0, 33'h0, 33'h0, 33'h1_00000033);
    chk("bc_wait_cnt", accept_cnt, 16'd5);
    out_ready = 16'h0008;
    #1 chk("bc_ready", in_ready, 1'b1);
    tick;
    chk_outs("bc", 33'h1_B0B0B0B0, 33'h1_B0B0B0B0, 33'h1_B0B0B0B0, 33'h1_B0B0B0B0);
    chk_upper("bc");
    chk("bc_cnt", accept_cnt, 16'd6);
    out_ready = '0; in_bcast = 1'b0; in_valid = 1'b0;

    // Out-of-range destination: accepted, dropped, sticky error.
    in_valid = 1'b1; in_sel = 4'd7; in_data = 32'h77;
    #1 chk("err_ready", in_ready, 1'b1);
    tick;
    chk("err_flag", err_sel, 1'b1);
    chk("err_cnt", accept_cnt, 16'd6);
    chk_outs("err", 33'h1_B0B0B0B0, 33'h1_B0B0B0B0, 33'h1_B0B0B0B0, 33'h1_B0B0B0B0);
    chk_upper("err");
    in_valid = 1'b0;
    tick;
    chk("err_sticky", err_sel, 1'b1);

    // Asynchronous reset mid-cycle with all slots full.
    #2 rst_n = 1'b0;
    in_valid = 1'b1; in_sel = 4'd0; in_data = 32'h5A;
    #1;
    chk_outs("arst", 33'h0, 33'h0, 33'h0, 33'h0);
    chk("arst_err", err_sel, 1'b0);
    chk("arst_cnt", accept_cnt, 16'h0);
    chk("arst_ready", in_ready, 1'b0);
    tick;
    chk("arst_noacc_o0", o[0], 33'h0);
    chk("arst_noacc_cnt", accept_cnt, 16'h0);
    #2 rst_n = 1'b1; in_data = 32'hA5;
    #1 chk("rel_ready", in_ready, 1'b1);
    tick;
    chk("rel_o0", o[0], 33'h1_000000A5);
    chk("rel_cnt", accept_cnt, 16'd1);

    // Ready bits of nonexistent destinations have no effect.
    in_valid = 1'b0; out_ready = 16'hFFF0;
    tick;
    chk("inact_rdy_o0", o[0], 33'h1_000000A5);

    // Counter wrap: stream into slot 0 while it drains every edge.
    out_ready = 16'h0001; in_valid = 1'b1; in_sel = 4'd0;
    for (int i = 0; i < 65534; i++) begin
      in_data = 32'(i);
      tick;
    end
    chk("wrap_ffff", accept_cnt, 16'hFFFF);
    chk("wrap_ready", in_ready, 1'b1);
    chk("wrap_o0", o[0], {1'b1, 32'(65533)});
    in_data = 32'h1234;
    tick;
    chk("wrap_zero", accept_cnt, 16'h0000);
    chk("wrap_o0b", o[0], 33'h1_00001234);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
